// File: rtl/joybus_pkg.sv
// Shared joybus definitions: bit timing, transmitter states
// and the poll command bytes used by the console port.
package joybus_pkg;

   localparam int CLK_PER_US_DEF = 25;

   // Cycles in n_us microseconds at cpu clk cycles per us.
   function automatic int us_cyc(input int cpu, input int n_us);
      return cpu * n_us;
   endfunction

   localparam int BIT_T    = 4 * CLK_PER_US_DEF;
   localparam int SHORT    = CLK_PER_US_DEF;
   localparam int LONG     = 3 * CLK_PER_US_DEF;
   localparam int STOP     = CLK_PER_US_DEF;
   localparam int STOP_LOW = 2 * CLK_PER_US_DEF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOW,
      ST_HIGH,
      ST_STOP,
      ST_FIN
   } console_tx_state_t;

   localparam logic [7:0] CMD_POLL     = 8'h40;
   localparam logic [7:0] CMD_POLL_ARG = 8'h03;

endpackage

// File: rtl/joybus_bit_timer.sv
// Phase timer: ld_i restarts counting with a new length,
// tc_o is high on the last cycle of that length.
//   clk, rst_n : clock, async active-low reset
//   ld_i       : restart with len_i (takes effect next cycle)
//   len_i      : phase length in cycles (>= 1)
//   tc_o       : terminal count, last cycle of the phase
module joybus_bit_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ld_i,
   input  logic [7:0] len_i,
   output logic       tc_o
);

   logic [7:0] cnt_q;
   logic [7:0] len_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         len_q <= '0;
      end else if (ld_i) begin
         cnt_q <= '0;
         len_q <= len_i;
      end else begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   assign tc_o = (cnt_q == len_q - 8'd1);

endmodule

// File: rtl/console_tx.sv
// Joybus transmitter for the console port: sends 1..MAX_BYTES
// bytes MSB first, then a controller stop bit.
//   start/tx_len/tx_data : launch request, sampled in IDLE
//   abort                : cancel a transfer in progress
//   JB_TX_OE             : 1 pulls the open-drain line low
//   busy/done            : transfer active / normal completion
module console_tx
   import joybus_pkg::*;
#(
   parameter int CLK_PER_US = 25,
   parameter int MAX_BYTES  = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [3:0]             tx_len,
   input  logic [8*MAX_BYTES-1:0] tx_data,
   input  logic                   abort,
   output logic                   JB_TX_OE,
   output logic                   busy,
   output logic                   done
);

   localparam int W = 8 * MAX_BYTES;

   localparam logic [7:0] T_BIT   = 8'(us_cyc(CLK_PER_US, 4));
   localparam logic [7:0] T_SHORT = 8'(us_cyc(CLK_PER_US, 1));
   localparam logic [7:0] T_LONG  = 8'(us_cyc(CLK_PER_US, 3));
   localparam logic [7:0] T_STOPL = 8'(us_cyc(CLK_PER_US, 2));

   console_tx_state_t state_q;
   logic [W-1:0]      sh_q;
   logic [6:0]        bcnt_q;
   logic [6:0]        btgt_q;
   logic              oe_q;
   logic              busy_q;
   logic              done_q;

   logic              tmr_ld;
   logic [7:0]        tmr_len;
   logic              tmr_tc;
   logic              accept;
   logic              last_bit;

   function automatic logic [7:0] low_len(input logic b);
      return b ? T_SHORT : T_LONG;
   endfunction

   // abort in IDLE swallows a simultaneous start
   assign accept = start && !abort && (tx_len != 4'd0)
                && ({28'd0, tx_len} <= 32'(MAX_BYTES));

   assign last_bit = (bcnt_q + 7'd1 == btgt_q);

   joybus_bit_timer u_tmr (
      .clk   (clk),
      .rst_n (rst_n),
      .ld_i  (tmr_ld),
      .len_i (tmr_len),
      .tc_o  (tmr_tc)
   );

   // Timer reload: the length of the phase being entered.
   // In HIGH the next bit is sh_q[W-2], the shift lands
   // on the same edge.
   always_comb begin
      tmr_ld  = 1'b0;
      tmr_len = 8'd0;
      case (state_q)
         ST_IDLE: begin
            tmr_ld  = accept;
            tmr_len = low_len(tx_data[W-1]);
         end
         ST_LOW: begin
            tmr_ld  = tmr_tc;
            tmr_len = T_BIT - low_len(sh_q[W-1]);
         end
         ST_HIGH: begin
            tmr_ld  = tmr_tc;
            tmr_len = last_bit ? T_STOPL : low_len(sh_q[W-2]);
         end
         ST_STOP: begin
            tmr_ld  = 1'b0;
            tmr_len = 8'd0;
         end
         default: begin
            tmr_ld  = 1'b0;
            tmr_len = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sh_q    <= '0;
         bcnt_q  <= '0;
         btgt_q  <= '0;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (abort && state_q != ST_IDLE) begin
         state_q <= ST_IDLE;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (accept) begin
                  sh_q    <= tx_data;
                  bcnt_q  <= '0;
                  btgt_q  <= {tx_len, 3'b000};
                  state_q <= ST_LOW;
                  oe_q    <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            ST_LOW: begin
               if (tmr_tc) begin
                  state_q <= ST_HIGH;
                  oe_q    <= 1'b0;
               end
            end
            ST_HIGH: begin
               if (tmr_tc) begin
                  bcnt_q <= bcnt_q + 7'd1;
                  oe_q   <= 1'b1;
                  if (last_bit) begin
                     state_q <= ST_STOP;
                  end else begin
                     sh_q    <= sh_q << 1;
                     state_q <= ST_LOW;
                  end
               end
            end
            ST_STOP: begin
               if (tmr_tc) begin
                  state_q <= ST_FIN;
                  oe_q    <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            ST_FIN: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               oe_q    <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign JB_TX_OE = oe_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_console_tx.sv
// Self-checking bench for console_tx: waveform model built
// from bit-encoding rules, plus a run-length decoder.
module tb_console_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  tx_len;
   logic [79:0] tx_data;
   logic        abort;
   logic        oe;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   console_tx #(.CLK_PER_US(25), .MAX_BYTES(10)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .tx_len   (tx_len),
      .tx_data  (tx_data),
      .abort    (abort),
      .JB_TX_OE (oe),
      .busy     (busy),
      .done     (done)
   );

   int n_cmp;
   int n_bad;
   bit exp_q[$];
   bit obs_q[$];

   task automatic chk(input string tag, input logic [79:0] obs,
                      input logic [79:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected OE per cycle: each bit is 100 cycles, low 25
   // for a one and 75 for a zero, then 50 stop-low cycles.
   task automatic model(input int n, input logic [79:0] d);
      exp_q.delete();
      for (int i = 0; i < 8 * n; i++) begin
         int lo;
         lo = d[79-i] ? 25 : 75;
         repeat (lo) exp_q.push_back(1'b1);
         repeat (100 - lo) exp_q.push_back(1'b0);
      end
      repeat (50) exp_q.push_back(1'b1);
   endtask

   // Decode observed low-run widths back into bytes.
   task automatic decode(input int n, input logic [79:0] d,
                         input string tag);
      logic [79:0] dec;
      logic [79:0] mask;
      int run, nb, bad, stops;
      dec = '0; run = 0; nb = 0; bad = 0; stops = 0;
      for (int i = 0; i < obs_q.size(); i++) begin
         if (obs_q[i]) run++;
         else if (run != 0) begin
            if (run == 25 || run == 75) begin
               if (nb < 80) dec[79-nb] = (run == 25);
               nb++;
            end else if (run == 50) stops++;
            else bad++;
            run = 0;
         end
      end
      mask = ~80'd0 << (80 - 8 * n);
      chk({tag, " nbits"}, 80'(nb), 80'(8 * n));
      chk({tag, " decoded"}, dec, d & mask);
      chk({tag, " stop/bad"}, 80'(stops * 1000 + bad), 80'd1000);
   endtask

   // Called at a negedge; returns at the negedge of the
   // first IDLE cycle after the transfer (back-to-back ready).
   task automatic send(input string tag, input int n,
                       input logic [79:0] d, input bit jam);
      int sz, last, werr, berr, dcnt, dat;
      model(n, d);
      obs_q.delete();
      sz = exp_q.size();
      last = sz + 2;
      werr = 0; berr = 0; dcnt = 0; dat = -1;
      start = 1'b1; tx_len = 4'(n); tx_data = d;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= last; k++) begin
         bit eo;
         eo = (k <= sz) ? exp_q[k-1] : 1'b0;
         obs_q.push_back(oe);
         if (oe !== eo) werr++;
         if (busy !== (k <= sz + 1)) berr++;
         if (done === 1'b1) begin
            dcnt++;
            if (dat < 0) dat = k;
         end
         if (jam && k <= sz) begin
            start   = 1'($urandom_range(0, 1));
            tx_len  = 4'($urandom_range(0, 15));
            tx_data = {$urandom(), $urandom(), 16'($urandom())};
         end else start = 1'b0;
         if (k < last) @(negedge clk);
      end
      chk({tag, " oe errs"}, 80'(werr), 80'd0);
      chk({tag, " busy errs"}, 80'(berr), 80'd0);
      chk({tag, " done count"}, 80'(dcnt), 80'd1);
      chk({tag, " done cycle"}, 80'(dat), 80'(sz + 1));
      decode(n, d, tag);
   endtask

   initial begin
      logic [79:0] d;
      int werr;
      logic any;
      n_cmp = 0; n_bad = 0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      tx_len = '0; tx_data = '0;
      repeat (3) @(negedge clk);
      chk("reset oe", 80'(oe), 80'd0);
      chk("reset busy", 80'(busy), 80'd0);
      chk("reset done", 80'(done), 80'd0);
      rst_n = 1'b1;
      @(negedge clk);

      send("a5", 1, {8'hA5, 72'd0}, 1'b0);
      send("gc", 8, {64'h0080_8080_8080_0000, 16'd0}, 1'b0);

      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         start = 1'b1;
         tx_len = (j == 0) ? 4'd0 : 4'd11;
         tx_data = {$urandom(), $urandom(), 16'($urandom())};
         @(negedge clk);
         start = 1'b0;
         any = 1'b0;
         repeat (30) begin
            any = any | oe | busy | done;
            @(negedge clk);
         end
         chk((j == 0) ? "len0 idle" : "len11 idle", 80'(any), 80'd0);
      end

      abort = 1'b1; start = 1'b1; tx_len = 4'd2;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      any = 1'b0;
      repeat (20) begin
         any = any | oe | busy | done;
         @(negedge clk);
      end
      chk("abort idle start", 80'(any), 80'd0);

      d = {$urandom(), $urandom(), 16'($urandom())};
      model(3, d);
      start = 1'b1; tx_len = 4'd3; tx_data = d;
      @(negedge clk);
      start = 1'b0;
      werr = 0;
      for (int k = 1; k <= 300; k++) begin
         if (oe !== exp_q[k-1] || busy !== 1'b1) werr++;
         if (k < 300) @(negedge clk);
      end
      chk("abort pre errs", 80'(werr), 80'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort oe301", 80'(oe), 80'd0);
      chk("abort busy301", 80'(busy), 80'd0);
      werr = 0;
      for (int k = 301; k <= 1300; k++) begin
         if ({oe, busy, done} !== 3'b000) werr++;
         @(negedge clk);
      end
      chk("abort post errs", 80'(werr), 80'd0);
      send("post_abort", 1, {$urandom(), $urandom(), 16'($urandom())}, 1'b0);

      send("jam", 2, {$urandom(), $urandom(), 16'($urandom())}, 1'b1);

      for (int r = 0; r < 3; r++) begin
         send("rnd", $urandom_range(1, 10),
              {$urandom(), $urandom(), 16'($urandom())}, 1'b0);
      end

      start = 1'b1; tx_len = 4'd1; tx_data = '0;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre-reset oe", 80'(oe), 80'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset oe", 80'(oe), 80'd0);
      chk("async reset busy", 80'(busy), 80'd0);
      chk("async reset done", 80'(done), 80'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("after reset oe", 80'(oe), 80'd0);
      chk("after reset busy", 80'(busy), 80'd0);
      send("post_rst", 1, {$urandom(), $urandom(), 16'($urandom())}, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/console_tx.md
# console_tx

Joybus transmitter for the console-facing port. It serializes a controller response of 1–10 bytes onto the open-drain data line, using standard joybus bit timing, and finishes with a controller stop bit. It sits beside the console receiver. Top-level control launches it once the receiver reports a completed command, and it hands the line back to the receiver when done.

## Interface
- CLK_PER_US, default 25: clk cycles per microsecond; 25 corresponds to a 25 MHz clk.
- MAX_BYTES, default 10: capacity of the data input, in bytes.
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle launch request; sampled only in IDLE.
- tx_len  input  4  number of bytes to send; valid range 1..MAX_BYTES; sampled with start.
- tx_data  input  8*MAX_BYTES  payload, left-justified; bit [8*MAX_BYTES-1] is sent first; sampled with start.
- abort  input  1  synchronous cancel of any transfer in progress.
- JB_TX_OE  output  1  1 = pull the line low; 0 = release the line (external tristate/open-drain).
- busy  output  1  high from the cycle after an accepted start through the final release cycle.
- done  output  1  one-cycle pulse when a transfer completes normally.

## Operation
- Derived constants:
  - BIT_T = 4*CLK_PER_US (100 cycles).
  - SHORT = CLK_PER_US (25).
  - LONG = 3*CLK_PER_US (75).
  - STOP_LOW = 2*CLK_PER_US (50).
- Bit encoding, low phase first:
  - '0' = LONG low, then SHORT high.
  - '1' = SHORT low, then LONG high.
- Stop bit: STOP_LOW low, then release.
- Data path:
  - Shift register of 8*MAX_BYTES bits, loaded with tx_data on accept; shifts left by 1 at the end of each bit.
  - Bit counter is 7 bits; the target is 8*tx_len, latched on accept.
  - Cycle counter is 8 bits; it resets at every phase change.
- States: IDLE, LOW, HIGH, STOP, FIN.
  - IDLE: OE=0, busy=0. If start and 1≤tx_len≤MAX_BYTES, load registers and go to LOW. If tx_len is 0 or >MAX_BYTES, ignore start (no busy, no done).
  - LOW: OE=1. Leave after (msb ? SHORT : LONG) cycles and go to HIGH.
  - HIGH: OE=0. Leave after BIT_T minus the low time.
    - If the bit count reaches the target, go to STOP.
    - Otherwise shift and go to LOW.
  - STOP: OE=1 for STOP_LOW cycles, then go to FIN.
  - FIN: OE=0, busy=1, done=1 for exactly one cycle, then go to IDLE.
- start while busy: ignored, with no effect on the transfer in progress.
- abort:
  - In any non-IDLE state, the next state is IDLE and OE is 0 from the next cycle; done is never pulsed.
  - abort has priority over every other transition.
  - abort in IDLE has no effect, even when start arrives in the same cycle (start is then ignored).
- Reset mid-transfer: OE is released immediately (asynchronously) and the FSM returns to IDLE.

## Timing
- Reset values: JB_TX_OE=0, busy=0, done=0, state IDLE, all counters and the shift register 0.
- All outputs are registered.
- First OE=1 appears the cycle after start is sampled; busy rises the same cycle.
- Every data bit is exactly BIT_T cycles; the low phase is exactly SHORT or LONG cycles.
- Total OE activity for N bytes: 800*N data cycles, then 50 stop-low cycles.
- FIN follows the last stop-low cycle. done and busy fall together on the cycle after FIN.
- Back-to-back operation: a start in the cycle IDLE is re-entered is accepted.

## Structure
- Shared package joybus_pkg holds:
  - Timing constants: BIT_T, SHORT, LONG, console STOP (1 µs) and controller STOP_LOW (2 µs), the latter two shared with the receiver.
  - The console_tx_state_t enum.
  - The poll command constant 8'h40, second byte 8'h03.
- One sub-module, joybus_bit_timer: a cycle counter with load/terminal-count, reusable by the receiver.
- Everything else is inline in console_tx.

## Test plan
- start, tx_len=1, tx_data[79:72]=8'hA5 → OE low-phase widths 25,75,25,75,75,25,75,25; each bit period 100 cycles; then 50 low; done once at cycle 851.
- start, tx_len=8, 64-bit GC status 0x0080_8080_8080_0000 (rest 0) → 64 bits decoded by a bench model match; stop 50 low; done exactly once.
- tx_len=0 and tx_len=11 with start → OE, busy and done stay 0.
- abort asserted at cycle 300 of a 3-byte send → OE 0 from cycle 301; busy low; no done; a fresh start is accepted afterwards.
- start pulsed repeatedly during an active 2-byte send → waveform identical to a single start; one done.
- rst_n asserted during the LOW phase → OE drops without waiting for clk; all outputs at reset values.
